// File: rtl/iob_cpu_bus_router.sv
// -----------------------------------------------------------------------------
// iob_cpu_bus_router
//
// Bridge from the PicoRV32 native memory interface (valid/ready) to N_SLAVES
// IOb slave channels (avalid/ready request, rvalid response). A single
// registered FSM accepts one CPU transaction at a time and routes it by the
// top SEL_W address bits. It returns the slave read data, or a generated
// acknowledge for writes, to the core with a one-cycle cpu_ready_o pulse.
//
// Flow: IDLE -> REQ -> (WAIT_R for reads) -> RESP -> IDLE.
// Out-of-range slave indices skip straight to RESP with rdata 0 and set the
// sticky err_o flag.
//
// Optional feature (macro IOB_CPU_ROUTER_TIMEOUT_EN):
//   A TIMEOUT_W counter runs while in REQ/WAIT_R. When it reaches
//   2^TIMEOUT_W-1 the transaction is abandoned: avalid drops, the core gets a
//   completion with rdata 0, and err_o is set. Without the macro the FSM waits
//   indefinitely and TIMEOUT_W is unused.
//
// Ports:
//   clk_i, rst_n_i  clock (rising edge), asynchronous active-low reset
//   cke_i           clock enable; all state holds while low
//   cpu_valid_i     core request valid
//   cpu_addr_i      byte address; top SEL_W bits select the slave
//   cpu_wdata_i     write data
//   cpu_wstrb_i     write strobes; all zero means read
//   cpu_rdata_o     read data, valid while cpu_ready_o is high
//   cpu_ready_o     one-cycle completion pulse
//   s_avalid_o      per-channel request valid (one-hot or zero)
//   s_addr_o        shared registered address
//   s_wdata_o       shared registered write data
//   s_wstrb_o       shared registered write strobes
//   s_ready_i       per-channel request accept
//   s_rvalid_i      per-channel read data valid
//   s_rdata_i       per-channel read data, channel k at [k*DATA_W +: DATA_W]
//   err_o           sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module iob_cpu_bus_router #(
   parameter int  ADDR_W    = 32,
   parameter int  DATA_W    = 32,
   parameter int  N_SLAVES  = 4,
   parameter int  SEL_W     = 2,
   parameter int  TIMEOUT_W = 8,
   localparam int WSTRB_W   = DATA_W / 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         cke_i,

   input  logic                         cpu_valid_i,
   input  logic [ADDR_W-1:0]            cpu_addr_i,
   input  logic [DATA_W-1:0]            cpu_wdata_i,
   input  logic [WSTRB_W-1:0]           cpu_wstrb_i,
   output logic [DATA_W-1:0]            cpu_rdata_o,
   output logic                         cpu_ready_o,

   output logic [N_SLAVES-1:0]          s_avalid_o,
   output logic [ADDR_W-1:0]            s_addr_o,
   output logic [DATA_W-1:0]            s_wdata_o,
   output logic [WSTRB_W-1:0]           s_wstrb_o,
   input  logic [N_SLAVES-1:0]          s_ready_i,
   input  logic [N_SLAVES-1:0]          s_rvalid_i,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,

   output logic                         err_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_R,
      ST_RESP
   } state_t;

   state_t              state_q;
   logic [N_SLAVES-1:0] sel_oh_q;    // registered slave select, one-hot

   logic [SEL_W-1:0]    sel_d;
   logic [N_SLAVES-1:0] sel_oh_d;
   logic                ready_hit;
   logic                rvalid_hit;
   logic                is_write;
   logic                to_hit;
   logic [DATA_W-1:0]   rdata_sel;

   // Slave index from the address MSBs. Shifting a single 1 by an index at or
   // beyond N_SLAVES pushes it out of the vector, so an all-zero one-hot
   // doubles as the out-of-range indication.
   assign sel_d    = cpu_addr_i[ADDR_W-1 -: SEL_W];
   assign sel_oh_d = N_SLAVES'(1) << sel_d;

   // In REQ s_avalid_o equals sel_oh_q, so masking with it ignores ready on
   // every other channel. rvalid is only honoured in WAIT_R by the FSM.
   assign ready_hit  = |(s_ready_i & s_avalid_o);
   assign rvalid_hit = |(s_rvalid_i & sel_oh_q);
   assign is_write   = |s_wstrb_o;

   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      rdata_sel = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_oh_q[k]) rdata_sel = s_rdata_i[k*DATA_W +: DATA_W];
      end
   end

`ifdef IOB_CPU_ROUTER_TIMEOUT_EN
   // All ones except the LSB: the value that becomes 2^TIMEOUT_W-1 on the
   // counting edge, so the abandon happens on that same edge.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = ~TIMEOUT_W'(1);

   logic [TIMEOUT_W-1:0] to_cnt_q;

   // REQ is entered only from IDLE, so clearing in IDLE is the same as
   // clearing on REQ entry. RESP holds the value; it is never observed there.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         to_cnt_q <= '0;
      end else if (cke_i) begin
         if (state_q == ST_IDLE) begin
            to_cnt_q <= '0;
         end else if (state_q == ST_REQ || state_q == ST_WAIT_R) begin
            to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
         end
      end
   end

   assign to_hit = (state_q == ST_REQ || state_q == ST_WAIT_R) && (to_cnt_q == TO_LAST);
`else
   logic [TIMEOUT_W-1:0] unused_timeout_cnt;
   assign unused_timeout_cnt = '0;
   assign to_hit             = 1'b0;
`endif

   // Transaction FSM. Every output is a register written here, so there is no
   // combinational path from cpu_* to s_* or back to the core.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         sel_oh_q    <= '0;
         s_avalid_o  <= '0;
         s_addr_o    <= '0;
         s_wdata_o   <= '0;
         s_wstrb_o   <= '0;
         cpu_rdata_o <= '0;
         cpu_ready_o <= 1'b0;
         err_o       <= 1'b0;
      end else if (cke_i) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         cpu_ready_o <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (cpu_valid_i) begin
                  s_addr_o  <= cpu_addr_i;
                  s_wdata_o <= cpu_wdata_i;
                  s_wstrb_o <= cpu_wstrb_i;
                  sel_oh_q  <= sel_oh_d;
                  if (sel_oh_d == '0) begin
                     // No such slave: complete immediately with zero data.
                     cpu_rdata_o <= '0;
                     cpu_ready_o <= 1'b1;
                     err_o       <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     s_avalid_o <= sel_oh_d;
                     state_q    <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               // A normal accept wins over a timeout on the same edge.
               if (ready_hit) begin
                  s_avalid_o <= '0;
                  if (is_write) begin
                     cpu_rdata_o <= '0;
                     cpu_ready_o <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     state_q <= ST_WAIT_R;
                  end
               end else if (to_hit) begin
                  s_avalid_o  <= '0;
                  cpu_rdata_o <= '0;
                  cpu_ready_o <= 1'b1;
                  err_o       <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end

            ST_WAIT_R: begin
               if (rvalid_hit) begin
                  cpu_rdata_o <= rdata_sel;
                  cpu_ready_o <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (to_hit) begin
                  cpu_rdata_o <= '0;
                  cpu_ready_o <= 1'b1;
                  err_o       <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end

            ST_RESP: begin
               // cpu_ready_o falls through the default above.
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_avalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      $onehot0(s_avalid_o));

   a_ready_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (cpu_ready_o && cke_i) |=> !cpu_ready_o);

   a_no_req_at_resp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      cpu_ready_o |-> (s_avalid_o == '0));
`endif

endmodule

// File: tb/tb_iob_cpu_bus_router.sv
// -----------------------------------------------------------------------------
// tb_iob_cpu_bus_router
//
// Drives CPU transactions into iob_cpu_bus_router (N_SLAVES=3, so index 3 is
// out of range) and plays the slaves cycle by cycle. A reference model derived
// from the transaction rules predicts, per cycle, which channel requests,
// when the core sees completion, the returned data and the error flag.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iob_cpu_bus_router;

   localparam int N        = 3;
   localparam int DW       = 32;
   localparam int TW       = 4;
   localparam int TO_LIMIT = (1 << TW) - 1;
`ifdef IOB_CPU_ROUTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            cke       = 1'b1;
   logic            cpu_valid = 1'b0;
   logic [31:0]     cpu_addr  = '0;
   logic [DW-1:0]   cpu_wdata = '0;
   logic [3:0]      cpu_wstrb = '0;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_ready;
   logic [N-1:0]    s_avalid;
   logic [31:0]     s_addr;
   logic [DW-1:0]   s_wdata;
   logic [3:0]      s_wstrb;
   logic [N-1:0]    s_ready   = '0;
   logic [N-1:0]    s_rvalid  = '0;
   logic [N*DW-1:0] s_rdata   = '0;
   logic            err;

   int n_checks = 0;
   int n_errors = 0;
   bit err_exp  = 1'b0;

   iob_cpu_bus_router #(
      .ADDR_W   (32),
      .DATA_W   (DW),
      .N_SLAVES (N),
      .SEL_W    (2),
      .TIMEOUT_W(TW)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .cke_i      (cke),
      .cpu_valid_i(cpu_valid),
      .cpu_addr_i (cpu_addr),
      .cpu_wdata_i(cpu_wdata),
      .cpu_wstrb_i(cpu_wstrb),
      .cpu_rdata_o(cpu_rdata),
      .cpu_ready_o(cpu_ready),
      .s_avalid_o (s_avalid),
      .s_addr_o   (s_addr),
      .s_wdata_o  (s_wdata),
      .s_wstrb_o  (s_wstrb),
      .s_ready_i  (s_ready),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete transaction. rw = extra cycles before the slave accepts,
   // vw = extra cycles between accept and rvalid. noise: 0 quiet, 1 random
   // activity on other channels, 2 other channels permanently active.
   task automatic run_txn(input logic [31:0] addr, input logic [DW-1:0] wdata,
                          input logic [3:0] wstrb, input int rw, input int vw,
                          input logic [DW-1:0] rd_data, input int noise);
      logic [1:0]   sel;
      bit           in_range, is_rd, timed_out;
      int           wait_cycles, done, req_last;
      logic [DW-1:0] exp_rdata;
      logic [N-1:0] oh, exp_av, mask;

      sel       = addr[31:30];
      in_range  = int'(sel) < N;
      is_rd     = (wstrb == 4'h0);
      timed_out = 1'b0;
      oh        = in_range ? (N'(1) << sel) : '0;

      // Reference model: completion cycle, request window and return data.
      if (!in_range) begin
         done      = 1;
         req_last  = 0;
         exp_rdata = '0;
      end else begin
         wait_cycles = is_rd ? (2 + rw + vw) : (1 + rw);
         if (TO_EN && wait_cycles > TO_LIMIT) begin
            timed_out = 1'b1;
            done      = TO_LIMIT + 1;
            req_last  = (1 + rw < TO_LIMIT) ? 1 + rw : TO_LIMIT;
            exp_rdata = '0;
         end else begin
            done      = wait_cycles + 1;
            req_last  = 1 + rw;
            exp_rdata = is_rd ? rd_data : '0;
         end
      end
      if (!in_range || timed_out) err_exp = 1'b1;

      // Cycle 0: IDLE, core presents the request.
      @(negedge clk);
      check("idle_ready", 64'(cpu_ready), 64'(0));
      check("idle_avalid", 64'(s_avalid), 64'(0));
      cpu_valid = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_wstrb = wstrb;
      s_ready   = '0;
      s_rvalid  = '0;

      for (int c = 1; c <= done; c++) begin
         @(negedge clk);
         exp_av = (c <= req_last) ? oh : '0;
         check("avalid", 64'(s_avalid), 64'(exp_av));
         if (exp_av != '0) begin
            check("s_addr", 64'(s_addr), 64'(addr));
            check("s_wdata", 64'(s_wdata), 64'(wdata));
            check("s_wstrb", 64'(s_wstrb), 64'(wstrb));
         end
         check("cpu_ready", 64'(cpu_ready), 64'(c == done));
         if (c == done) begin
            check("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
            check("err", 64'(err), 64'(err_exp));
         end

         // Core keeps valid up with scrambled fields until completion.
         cpu_valid = (c < done);
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         cpu_wstrb = 4'($urandom);

         for (int k = 0; k < N; k++) s_rdata[k*DW +: DW] = $urandom;
         mask     = (noise == 2) ? ~oh : ((noise == 1) ? (N'($urandom) & ~oh) : '0);
         s_ready  = mask;
         s_rvalid = (noise == 2) ? ~oh : (N'($urandom) & mask);
         if (in_range) begin
            if (c == 1 + rw) s_ready = s_ready | oh;
            if (c <= 1 + rw) begin
               // rvalid during the request phase must be ignored.
               if (noise != 0 && $urandom_range(1, 0) == 1) s_rvalid = s_rvalid | oh;
            end else if (is_rd && c == 2 + rw + vw) begin
               s_rvalid = s_rvalid | oh;
               s_rdata[int'(sel)*DW +: DW] = rd_data;
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_avalid", 64'(s_avalid), 64'(0));
      check("rst_ready", 64'(cpu_ready), 64'(0));
      check("rst_rdata", 64'(cpu_rdata), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_s_addr", 64'(s_addr), 64'(0));
      rst_n = 1'b1;

      // Read ch2, zero-wait.
      run_txn(32'h8000_0010, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 0);
      // Write ch1 with ready stall.
      run_txn(32'h4000_0004, 32'hA5A5_A5A5, 4'hF, 3, 0, 32'h0, 0);
      // Out of range (index 3 with three slaves).
      run_txn(32'hC000_0000, 32'h0, 4'h0, 0, 0, 32'h0, 1);
      // Read ch2 with other channels constantly signalling.
      run_txn(32'h8000_0100, 32'h0, 4'h0, 1, 2, 32'hCAFE_F00D, 2);

      // Reset during WAIT_R.
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_addr  = 32'h4000_0020;
      cpu_wstrb = 4'h0;
      s_ready   = '0;
      s_rvalid  = '0;
      @(negedge clk);
      check("rstm_avalid_req", 64'(s_avalid), 64'(3'b010));
      s_ready = 3'b010;
      @(negedge clk);
      s_ready = '0;
      check("rstm_avalid_wait", 64'(s_avalid), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      check("rstm_avalid", 64'(s_avalid), 64'(0));
      check("rstm_ready", 64'(cpu_ready), 64'(0));
      check("rstm_rdata", 64'(cpu_rdata), 64'(0));
      check("rstm_err", 64'(err), 64'(0));
      check("rstm_s_addr", 64'(s_addr), 64'(0));
      err_exp   = 1'b0;
      cpu_valid = 1'b0;
      s_rvalid  = 3'b010;
      @(negedge clk);
      @(negedge clk);
      check("rstm_hold_ready", 64'(cpu_ready), 64'(0));
      s_rvalid = '0;
      rst_n    = 1'b1;
      run_txn(32'h4000_0020, 32'h0, 4'h0, 0, 1, 32'h0BAD_BEEF, 1);

      // Clock enable low freezes REQ even with ready asserted, then RESP.
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_addr  = 32'h0000_0040;
      cpu_wdata = 32'hDEAD_BEEF;
      cpu_wstrb = 4'hF;
      @(negedge clk);
      check("cke_avalid", 64'(s_avalid), 64'(3'b001));
      cke       = 1'b0;
      s_ready   = 3'b001;
      cpu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("cke_frozen_avalid", 64'(s_avalid), 64'(3'b001));
         check("cke_frozen_ready", 64'(cpu_ready), 64'(0));
      end
      cke = 1'b1;
      @(negedge clk);
      s_ready = '0;
      check("cke_resp_ready", 64'(cpu_ready), 64'(1));
      check("cke_resp_rdata", 64'(cpu_rdata), 64'(0));
      cke = 1'b0;
      @(negedge clk);
      check("cke_resp_hold", 64'(cpu_ready), 64'(1));
      cke = 1'b1;
      @(negedge clk);
      check("cke_resp_done", 64'(cpu_ready), 64'(0));

`ifdef IOB_CPU_ROUTER_TIMEOUT_EN
      // Slave never accepts: abandoned after the counter expires.
      run_txn(32'h0000_0000, 32'h0, 4'h0, 100, 0, 32'h0, 1);
      // Accept on the expiring edge wins; one later times out.
      run_txn(32'h4000_0000, 32'h1111_2222, 4'h3, TO_LIMIT - 1, 0, 32'h0, 0);
      run_txn(32'h4000_0000, 32'h3333_4444, 4'h3, TO_LIMIT, 0, 32'h0, 0);
`endif

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         logic [3:0] ws;
         ws = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom);
         run_txn($urandom, $urandom, ws, $urandom_range(4, 0), $urandom_range(4, 0),
                 $urandom, 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
